// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined main control unit: opcodes, functs, ALUFun,
// PC-source / writeback selects and the layout of the registered control bundle.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0a;
   localparam logic [5:0] OP_SLTIU  = 6'h0b;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_MUL    = 6'h1c;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a;
   localparam logic [5:0] F_SLTU = 6'h2b;

   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_MUL = 6'b000010;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_NEQ = 6'b110001;
   localparam logic [5:0] ALU_LT  = 6'b110101;
   localparam logic [5:0] ALU_LEZ = 6'b111101;
   localparam logic [5:0] ALU_LTZ = 6'b111011;
   localparam logic [5:0] ALU_GTZ = 6'b111111;

   localparam logic [2:0] PCSRC_SEQ    = 3'b000;
   localparam logic [2:0] PCSRC_BRANCH = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_JREG   = 3'b011;
   localparam logic [2:0] PCSRC_IRQ    = 3'b100;
   localparam logic [2:0] PCSRC_EXC    = 3'b101;

   localparam logic [1:0] REGDST_RD = 2'b00;
   localparam logic [1:0] REGDST_RT = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;
   localparam logic [1:0] REGDST_K0 = 2'b11;

   localparam logic [1:0] MEMTOREG_ALU = 2'b00;
   localparam logic [1:0] MEMTOREG_MEM = 2'b01;
   localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

   localparam int unsigned OFF_ALUFUN   = 0;
   localparam int unsigned OFF_ALUSRC1  = 6;
   localparam int unsigned OFF_ALUSRC2  = 7;
   localparam int unsigned OFF_SIGN     = 8;
   localparam int unsigned OFF_EXTOP    = 9;
   localparam int unsigned OFF_LUOP     = 10;
   localparam int unsigned OFF_MEMREAD  = 11;
   localparam int unsigned OFF_MEMWRITE = 12;
   localparam int unsigned OFF_REGWRITE = 13;
   localparam int unsigned OFF_REGDST   = 14;
   localparam int unsigned OFF_MEMTOREG = 16;
   localparam int unsigned CTRL_W       = 18;

   // Interrupts and exceptions both save PC+4 into $k0.
   function automatic logic [CTRL_W-1:0] k0_bundle();
      logic [CTRL_W-1:0] b;
      b = '0;
      b[OFF_REGWRITE] = 1'b1;
      b[OFF_REGDST +: 2] = REGDST_K0;
      b[OFF_MEMTOREG +: 2] = MEMTOREG_PC4;
      return b;
   endfunction

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational opcode/funct decoder: control bundle, sequential PC select and a
// flag saying whether the instruction belongs to the supported set.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0]        opcode_i,
   input  logic [5:0]        funct_i,
   output logic [CTRL_W-1:0] bundle_o,
   output logic [2:0]        pcsrc_o,
   output logic              valid_o
);

   logic [5:0] alufun;
   logic       alusrc1, alusrc2, sign, extop, luop, memread, memwrite, regwrite;
   logic [1:0] regdst, memtoreg;

   always_comb begin
      alufun   = ALU_ADD;
      alusrc1  = 1'b0;
      alusrc2  = 1'b0;
      sign     = 1'b0;
      extop    = 1'b0;
      luop     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      regdst   = REGDST_RD;
      memtoreg = MEMTOREG_ALU;
      pcsrc_o  = PCSRC_SEQ;
      valid_o  = 1'b1;
      case (opcode_i)
         OP_RTYPE: begin
            regwrite = 1'b1;
            case (funct_i)
               F_ADD:  sign = 1'b1;
               F_ADDU: ;
               F_SUB:  begin alufun = ALU_SUB; sign = 1'b1; end
               F_SUBU: alufun = ALU_SUB;
               F_AND:  alufun = ALU_AND;
               F_OR:   alufun = ALU_OR;
               F_XOR:  alufun = ALU_XOR;
               F_NOR:  alufun = ALU_NOR;
               F_SLL:  begin alufun = ALU_SLL; alusrc1 = 1'b1; end
               F_SRL:  begin alufun = ALU_SRL; alusrc1 = 1'b1; end
               F_SRA:  begin alufun = ALU_SRA; alusrc1 = 1'b1; end
               F_SLT:  begin alufun = ALU_LT; sign = 1'b1; end
               F_SLTU: alufun = ALU_LT;
               F_JR:   begin regwrite = 1'b0; pcsrc_o = PCSRC_JREG; end
               F_JALR: begin memtoreg = MEMTOREG_PC4; pcsrc_o = PCSRC_JREG; end
               default: begin regwrite = 1'b0; valid_o = 1'b0; end
            endcase
         end
         OP_J:   pcsrc_o = PCSRC_JUMP;
         OP_JAL: begin
            pcsrc_o  = PCSRC_JUMP;
            regwrite = 1'b1;
            regdst   = REGDST_RA;
            memtoreg = MEMTOREG_PC4;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
            pcsrc_o = PCSRC_BRANCH;
            sign    = 1'b1;
            extop   = 1'b1;
            case (opcode_i)
               OP_BEQ:  alufun = ALU_EQ;
               OP_BNE:  alufun = ALU_NEQ;
               OP_BLEZ: alufun = ALU_LEZ;
               OP_BGTZ: alufun = ALU_GTZ;
               default: alufun = ALU_LTZ;
            endcase
         end
         OP_ADDI:  begin alusrc2 = 1'b1; sign = 1'b1; extop = 1'b1; regwrite = 1'b1;
                         regdst = REGDST_RT; end
         OP_ADDIU: begin alusrc2 = 1'b1; extop = 1'b1; regwrite = 1'b1; regdst = REGDST_RT; end
         OP_SLTI:  begin alufun = ALU_LT; alusrc2 = 1'b1; sign = 1'b1; extop = 1'b1;
                         regwrite = 1'b1; regdst = REGDST_RT; end
         OP_SLTIU: begin alufun = ALU_LT; alusrc2 = 1'b1; extop = 1'b1; regwrite = 1'b1;
                         regdst = REGDST_RT; end
         OP_ANDI:  begin alufun = ALU_AND; alusrc2 = 1'b1; regwrite = 1'b1;
                         regdst = REGDST_RT; end
         OP_LUI:   begin alusrc2 = 1'b1; luop = 1'b1; regwrite = 1'b1; regdst = REGDST_RT; end
         OP_LW:    begin alusrc2 = 1'b1; extop = 1'b1; memread = 1'b1; regwrite = 1'b1;
                         regdst = REGDST_RT; memtoreg = MEMTOREG_MEM; end
         OP_SW:    begin alusrc2 = 1'b1; extop = 1'b1; memwrite = 1'b1; end
         OP_MUL:   begin alufun = ALU_MUL; sign = 1'b1; regwrite = 1'b1; end
         default:  valid_o = 1'b0;
      endcase
   end

   assign bundle_o = {memtoreg, regdst, regwrite, memwrite, memread, luop, extop, sign,
                      alusrc2, alusrc1, alufun};

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Main control unit: ID decode, interrupt/exception steering, a CTRL_STAGES-deep
// control shift register (EX..WB) and load-use hazard detection.
module ctrl_pipe_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned CTRL_STAGES = 3,
   parameter int unsigned PC_W        = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [PC_W-1:0] pc_in,
   input  logic            irq,
   input  logic            stall,
   input  logic            flush,
   output logic [2:0]      pcsrc,
   output logic            load_use_stall,
   output logic [5:0]      ex_alufun,
   output logic            ex_alusrc1,
   output logic            ex_alusrc2,
   output logic            ex_sign,
   output logic            ex_extop,
   output logic            ex_luop,
   output logic            mem_read,
   output logic            mem_write,
   output logic            wb_regwrite,
   output logic [1:0]      wb_regdst,
   output logic [1:0]      wb_memtoreg
);

   logic [CTRL_W-1:0] dec_bundle;
   logic [2:0]        dec_pcsrc;
   logic              dec_valid;

   ctrl_decode u_decode (
      .opcode_i (opcode),
      .funct_i  (funct),
      .bundle_o (dec_bundle),
      .pcsrc_o  (dec_pcsrc),
      .valid_o  (dec_valid)
   );

   logic              irq_pending_q, irq_pending_d;
   logic              irq_take, bubble;
   logic [4:0]        ex_rt_q, ex_rt_d;
   logic [CTRL_W-1:0] stage1_d;
   logic [CTRL_W-1:0] stage_q [CTRL_STAGES];

   always_comb begin
      bubble        = stall | flush | ~instr_valid;
      // Kernel mode masks interrupts; the request stays pending until user mode.
      irq_take      = (irq_pending_q | irq) & instr_valid & ~stall & ~flush & ~pc_in[PC_W-1];
      irq_pending_d = (irq_pending_q | irq) & ~irq_take;
      ex_rt_d       = bubble ? 5'd0 : id_rt;
      if (bubble) begin
         stage1_d = '0;
      end else if (irq_take || !dec_valid) begin
         stage1_d = k0_bundle();
      end else begin
         stage1_d = dec_bundle;
      end
      if (reset || !instr_valid) begin
         pcsrc = PCSRC_SEQ;
      end else if (irq_take) begin
         pcsrc = PCSRC_IRQ;
      end else if (!dec_valid) begin
         pcsrc = PCSRC_EXC;
      end else begin
         pcsrc = dec_pcsrc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_pending_q <= 1'b0;
         ex_rt_q       <= 5'd0;
      end else begin
         irq_pending_q <= irq_pending_d;
         ex_rt_q       <= ex_rt_d;
      end
   end

   for (genvar k = 0; k < CTRL_STAGES; k++) begin : gen_stage
      if (k == 0) begin : gen_first
         always_ff @(posedge clk) begin
            if (reset) stage_q[k] <= '0;
            else       stage_q[k] <= stage1_d;
         end
      end else begin : gen_next
         always_ff @(posedge clk) begin
            if (reset) stage_q[k] <= '0;
            else       stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign ex_alufun   = stage_q[0][OFF_ALUFUN +: 6];
   assign ex_alusrc1  = stage_q[0][OFF_ALUSRC1];
   assign ex_alusrc2  = stage_q[0][OFF_ALUSRC2];
   assign ex_sign     = stage_q[0][OFF_SIGN];
   assign ex_extop    = stage_q[0][OFF_EXTOP];
   assign ex_luop     = stage_q[0][OFF_LUOP];
   assign mem_read    = stage_q[1][OFF_MEMREAD];
   assign mem_write   = stage_q[1][OFF_MEMWRITE];
   assign wb_regwrite = stage_q[CTRL_STAGES-1][OFF_REGWRITE];
   assign wb_regdst   = stage_q[CTRL_STAGES-1][OFF_REGDST +: 2];
   assign wb_memtoreg = stage_q[CTRL_STAGES-1][OFF_MEMTOREG +: 2];

   assign load_use_stall = stage_q[0][OFF_MEMREAD] & (ex_rt_q != 5'd0) &
                           ((ex_rt_q == id_rs) | (ex_rt_q == id_rt)) & instr_valid;

   logic unused_bits;
   assign unused_bits = ^{pc_in[PC_W-2:0], stage_q[CTRL_STAGES-1][OFF_MEMWRITE:0]};

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: a 3-stage and a 5-stage instance share stimulus and are
// compared every cycle against an instruction-level reference model.
module tb_ctrl_pipe_unit;

   localparam logic [5:0] A_ADD = 6'b000000, A_SUB = 6'b000001, A_MUL = 6'b000010;
   localparam logic [5:0] A_AND = 6'b011000, A_OR = 6'b011110, A_XOR = 6'b010110;
   localparam logic [5:0] A_NOR = 6'b010001, A_SLL = 6'b100000, A_SRL = 6'b100001;
   localparam logic [5:0] A_SRA = 6'b100011, A_EQ = 6'b110011, A_NEQ = 6'b110001;
   localparam logic [5:0] A_LT = 6'b110101, A_LEZ = 6'b111101, A_LTZ = 6'b111011;
   localparam logic [5:0] A_GTZ = 6'b111111;

   typedef struct packed {
      logic [5:0] alufun;
      logic       src1, src2, sign, ext, lu, mr, mw, rw;
      logic [1:0] dst, m2r;
   } bnd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, instr_valid = 1'b0, irq = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [5:0]  opcode = '0, funct = '0;
   logic [4:0]  id_rs = '0, id_rt = '0;
   logic [31:0] pc_in = 32'h0040_0000;

   logic [2:0] a_pcsrc, b_pcsrc;
   logic       a_lus, b_lus;
   logic [5:0] a_alufun, b_alufun;
   logic       a_src1, a_src2, a_sign, a_ext, a_lu, a_mr, a_mw, a_rw;
   logic       b_src1, b_src2, b_sign, b_ext, b_lu, b_mr, b_mw, b_rw;
   logic [1:0] a_dst, a_m2r, b_dst, b_m2r;

   ctrl_pipe_unit #(.CTRL_STAGES(3), .PC_W(32)) dut_a (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
      .id_rs(id_rs), .id_rt(id_rt), .pc_in(pc_in), .irq(irq), .stall(stall), .flush(flush),
      .pcsrc(a_pcsrc), .load_use_stall(a_lus), .ex_alufun(a_alufun), .ex_alusrc1(a_src1),
      .ex_alusrc2(a_src2), .ex_sign(a_sign), .ex_extop(a_ext), .ex_luop(a_lu),
      .mem_read(a_mr), .mem_write(a_mw), .wb_regwrite(a_rw), .wb_regdst(a_dst),
      .wb_memtoreg(a_m2r)
   );

   ctrl_pipe_unit #(.CTRL_STAGES(5), .PC_W(32)) dut_b (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
      .id_rs(id_rs), .id_rt(id_rt), .pc_in(pc_in), .irq(irq), .stall(stall), .flush(flush),
      .pcsrc(b_pcsrc), .load_use_stall(b_lus), .ex_alufun(b_alufun), .ex_alusrc1(b_src1),
      .ex_alusrc2(b_src2), .ex_sign(b_sign), .ex_extop(b_ext), .ex_luop(b_lu),
      .mem_read(b_mr), .mem_write(b_mw), .wb_regwrite(b_rw), .wb_regdst(b_dst),
      .wb_memtoreg(b_m2r)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bnd_t mk(input logic [5:0] f, input logic s1, s2, sg, ex, lu, mr, mw,
                               rw, input logic [1:0] dst, m2r);
      return '{alufun: f, src1: s1, src2: s2, sign: sg, ext: ex, lu: lu, mr: mr, mw: mw,
               rw: rw, dst: dst, m2r: m2r};
   endfunction

   // Instruction-level meaning of each supported instruction; returns 0 if undefined.
   function automatic logic ref_dec(input logic [5:0] op, fn, output bnd_t b,
                                    output logic [2:0] pcs);
      logic ok;
      ok = 1'b1; pcs = 3'b000; b = '0;
      case (op)
         6'h00: case (fn)
            6'h20: b = mk(A_ADD, 0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h21: b = mk(A_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h22: b = mk(A_SUB, 0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h23: b = mk(A_SUB, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h24: b = mk(A_AND, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h25: b = mk(A_OR,  0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h26: b = mk(A_XOR, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h27: b = mk(A_NOR, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h00: b = mk(A_SLL, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h02: b = mk(A_SRL, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h03: b = mk(A_SRA, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h2a: b = mk(A_LT,  0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h2b: b = mk(A_LT,  0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
            6'h08: pcs = 3'b011;
            6'h09: begin b = mk(A_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2); pcs = 3'b011; end
            default: ok = 1'b0;
         endcase
         6'h02: pcs = 3'b010;
         6'h03: begin b = mk(A_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2); pcs = 3'b010; end
         6'h04: begin b = mk(A_EQ,  0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0); pcs = 3'b001; end
         6'h05: begin b = mk(A_NEQ, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0); pcs = 3'b001; end
         6'h06: begin b = mk(A_LEZ, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0); pcs = 3'b001; end
         6'h07: begin b = mk(A_GTZ, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0); pcs = 3'b001; end
         6'h01: begin b = mk(A_LTZ, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0); pcs = 3'b001; end
         6'h08: b = mk(A_ADD, 0, 1, 1, 1, 0, 0, 0, 1, 2'd1, 2'd0);
         6'h09: b = mk(A_ADD, 0, 1, 0, 1, 0, 0, 0, 1, 2'd1, 2'd0);
         6'h0a: b = mk(A_LT,  0, 1, 1, 1, 0, 0, 0, 1, 2'd1, 2'd0);
         6'h0b: b = mk(A_LT,  0, 1, 0, 1, 0, 0, 0, 1, 2'd1, 2'd0);
         6'h0c: b = mk(A_AND, 0, 1, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0);
         6'h0f: b = mk(A_ADD, 0, 1, 0, 0, 1, 0, 0, 1, 2'd1, 2'd0);
         6'h23: b = mk(A_ADD, 0, 1, 0, 1, 0, 1, 0, 1, 2'd1, 2'd1);
         6'h2b: b = mk(A_ADD, 0, 1, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0);
         6'h1c: b = mk(A_MUL, 0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Reference state: the control word sitting in each stage, plus EX's rt and pending irq.
   bnd_t       mp [1:8];
   logic [4:0] m_ex_rt = '0;
   logic       m_pend = 1'b0;
   logic       m_live = 1'b0;

   function automatic logic m_take();
      return (m_pend | irq) & instr_valid & !stall & !flush & !pc_in[31];
   endfunction

   function automatic logic [2:0] exp_pcsrc();
      bnd_t b;
      logic [2:0] p;
      logic ok;
      ok = ref_dec(opcode, funct, b, p);
      if (reset || !instr_valid) return 3'b000;
      if (m_take()) return 3'b100;
      if (!ok) return 3'b101;
      return p;
   endfunction

   always @(posedge clk) begin
      bnd_t b, k0;
      logic [2:0] p;
      logic ok;
      k0 = mk(A_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 2'd2);
      ok = ref_dec(opcode, funct, b, p);
      if (reset) begin
         for (int i = 1; i <= 8; i++) mp[i] = '0;
         m_ex_rt = '0;
         m_pend  = 1'b0;
         m_live  = 1'b1;
      end else begin
         for (int i = 8; i > 1; i--) mp[i] = mp[i-1];
         if (stall || flush || !instr_valid) begin
            mp[1] = '0;
            m_ex_rt = '0;
         end else begin
            mp[1] = (m_take() || !ok) ? k0 : b;
            m_ex_rt = id_rt;
         end
         m_pend = (m_pend | irq) & !m_take();
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         logic lus;
         lus = instr_valid & mp[1].mr & (m_ex_rt != 0) & ((m_ex_rt == id_rs) | (m_ex_rt == id_rt));
         chk("a_pcsrc", a_pcsrc, exp_pcsrc());
         chk("b_pcsrc", b_pcsrc, exp_pcsrc());
         chk("a_load_use", a_lus, lus);
         chk("b_load_use", b_lus, lus);
         chk("a_ex", {a_alufun, a_src1, a_src2, a_sign, a_ext, a_lu},
             {mp[1].alufun, mp[1].src1, mp[1].src2, mp[1].sign, mp[1].ext, mp[1].lu});
         chk("b_ex", {b_alufun, b_src1, b_src2, b_sign, b_ext, b_lu},
             {mp[1].alufun, mp[1].src1, mp[1].src2, mp[1].sign, mp[1].ext, mp[1].lu});
         chk("a_mem", {a_mr, a_mw}, {mp[2].mr, mp[2].mw});
         chk("b_mem", {b_mr, b_mw}, {mp[2].mr, mp[2].mw});
         chk("a_wb", {a_rw, a_dst, a_m2r}, {mp[3].rw, mp[3].dst, mp[3].m2r});
         chk("b_wb", {b_rw, b_dst, b_m2r}, {mp[5].rw, mp[5].dst, mp[5].m2r});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [5:0] op, fn, input logic [4:0] rs, rt);
      instr_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt;
   endtask

   logic [11:0] vecs [0:13] = '{{6'h00, 6'h22}, {6'h00, 6'h25}, {6'h00, 6'h00},
      {6'h00, 6'h2b}, {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h02, 6'h00}, {6'h03, 6'h00},
      {6'h05, 6'h00}, {6'h01, 6'h00}, {6'h08, 6'h00}, {6'h0c, 6'h00}, {6'h0f, 6'h00},
      {6'h1c, 6'h02}};

   initial begin
      // Reset with an undefined op in ID: pcsrc must still read 000.
      set_id(1, 6'h3f, 6'h00, 0, 0);
      #1 chk("pcsrc_in_reset", a_pcsrc, 3'b000);
      tick(); tick();
      chk("reset_ex", {a_alufun, a_src2, a_mr, a_mw}, 0);
      chk("reset_wb", {a_rw, a_dst, a_m2r}, 0);
      reset = 1'b0;

      // 1: add through the 3-stage pipe
      set_id(1, 6'h00, 6'h20, 1, 2);
      tick();
      chk("add_ex_alufun", a_alufun, 6'b000000);
      chk("add_ex_alusrc2", a_src2, 0);
      set_id(0, 0, 0, 0, 0);
      tick(); tick();
      chk("add_wb", {a_rw, a_dst, a_m2r}, {1'b1, 2'b00, 2'b00});

      // 2: load-use hazard
      set_id(1, 6'h23, 0, 1, 5);
      tick();
      set_id(1, 6'h00, 6'h20, 5, 6);
      #1 chk("lus_hit", a_lus, 1);
      stall = 1'b1;
      tick();
      chk("stall_bubble_ex", {a_alufun, a_src1, a_src2, a_sign, a_ext, a_lu}, 0);
      chk("lw_mem_read", a_mr, 1);
      stall = 1'b0;
      tick();
      set_id(1, 6'h23, 0, 1, 0);
      tick();
      set_id(1, 6'h00, 6'h20, 0, 0);
      #1 chk("lus_rt0", a_lus, 0);
      set_id(1, 6'h23, 0, 1, 7);
      tick();
      set_id(1, 6'h2b, 0, 1, 7);
      #1 chk("lus_rt_only", a_lus, 1);
      tick();

      // 3: irq pulse during stall
      set_id(1, 6'h00, 6'h20, 1, 2);
      stall = 1'b1; irq = 1'b1;
      #1 chk("irq_stalled0", a_pcsrc, 3'b000);
      tick();
      irq = 1'b0;
      #1 chk("irq_stalled1", a_pcsrc, 3'b000);
      tick();
      stall = 1'b0;
      #1 chk("irq_taken", a_pcsrc, 3'b100);
      tick();
      set_id(0, 0, 0, 0, 0);
      tick(); tick();
      chk("irq_wb", {a_rw, a_dst, a_m2r}, {1'b1, 2'b11, 2'b10});
      set_id(1, 6'h00, 6'h20, 1, 2);
      #1 chk("irq_cleared", a_pcsrc, 3'b000);
      tick();

      // 4: kernel mode masks irq
      pc_in = 32'h8000_0100; irq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("irq_masked", a_pcsrc, 3'b000);
         tick();
      end
      irq = 1'b0; pc_in = 32'h0040_0000;
      #1 chk("irq_unmasked", a_pcsrc, 3'b100);
      tick();

      // 5: exceptions, priority, flush
      set_id(1, 6'h3f, 0, 1, 2);
      #1 chk("exc_op", a_pcsrc, 3'b101);
      irq = 1'b1;
      #1 chk("irq_over_exc", a_pcsrc, 3'b100);
      tick();
      irq = 1'b0;
      pc_in = 32'h8000_0000;
      #1 chk("exc_kernel", a_pcsrc, 3'b101);
      tick();
      pc_in = 32'h0040_0000;
      set_id(1, 6'h00, 6'h3f, 1, 2);
      #1 chk("exc_funct", a_pcsrc, 3'b101);
      tick();
      set_id(1, 6'h04, 0, 1, 2);
      flush = 1'b1;
      #1 chk("beq_flush_pcsrc", a_pcsrc, 3'b001);
      tick();
      chk("flush_bubble", {a_alufun, a_sign, a_ext}, 0);
      flush = 1'b0;
      tick();
      chk("beq_ex", a_alufun, 6'b110011);
      for (int i = 0; i < 14; i++) begin
         logic [11:0] v;
         v = vecs[i];
         set_id(1, v[11:6], v[5:0], 3, 4);
         tick();
      end
      set_id(0, 0, 0, 0, 0);
      tick();

      // 6: 5-stage instance, sw and reset mid-flight
      set_id(1, 6'h2b, 0, 1, 2);
      tick();
      set_id(0, 0, 0, 0, 0);
      tick();
      chk("sw_mem_write", b_mw, 1);
      tick(); tick(); tick();
      chk("sw_wb_regwrite", b_rw, 0);
      set_id(1, 6'h00, 6'h20, 1, 2);
      tick();
      set_id(1, 6'h2b, 0, 1, 2);
      tick();
      set_id(0, 0, 0, 0, 0);
      tick();
      chk("sw2_mem_write", b_mw, 1);
      reset = 1'b1;
      tick();
      chk("reset_b_all", {b_pcsrc, b_lus, b_alufun, b_src1, b_src2, b_sign, b_ext, b_lu,
                          b_mr, b_mw, b_rw, b_dst, b_m2r}, 0);
      reset = 1'b0;

      // pending irq discarded by reset
      set_id(1, 6'h00, 6'h20, 1, 2);
      stall = 1'b1; irq = 1'b1;
      tick();
      irq = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0;
      #1 chk("reset_clears_pending", a_pcsrc, 3'b000);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
